ahblite_subbus_nslave: RTL and testbench
========================================

// Module: ahblite_subbus_nslave
// PURPOSE
// - Parametrised single-master AHB-Lite peripheral interconnect fanning one master port out to NSLV slaves.
// - Successor of the fixed five-peripheral sub-bus (DMAC/GPIO/UART/OLED/TIMER); sits behind the main bus matrix.
// - Adds a table-driven address map, a built-in default slave with two-cycle ERROR response, and a sticky decode-error status.
// PARAMETERS
// - NSLV      5                  number of slave ports (1..16)
// - SLV_BASE  {NSLV{32'h0}}      packed NSLV*32 base addresses; slot i = [32*i+31:32*i]
// - SLV_MASK  {NSLV{32'hFFFF0000}} packed NSLV*32 compare masks; hit(i) = (HADDR & MASK_i) == BASE_i
// PORTS
// - HCLK          in   1        bus clock
// - HRESETn       in   1        asynchronous active-low reset
// - HADDR_M/HTRANS_M/HWRITE_M/HSIZE_M/HBURST_M/HPROT_M/HWDATA_M  in  32/2/1/3/3/4/32  master request
// - HRDATA_M      out  32       read data to master
// - HREADY_M      out  1        ready to master; also the bus HREADY fed back to all slaves
// - HRESP_M       out  2        response to master (2'b00 OKAY, 2'b01 ERROR)
// - HSEL_S        out  NSLV     one-hot slave select, address phase
// - HADDR_S/HTRANS_S/HWRITE_S/HSIZE_S/HBURST_S/HPROT_S/HWDATA_S  out  32/2/1/3/3/4/32  broadcast to all slaves
// - HREADY_S      out  1        = HREADY_M
// - HRDATA_S      in   NSLV*32  packed slave read data
// - HREADYOUT_S   in   NSLV     slave ready outputs
// - HRESP_S       in   NSLV*2   packed slave responses
// - ERR_IRQ       out  1        sticky: an unmapped NONSEQ/SEQ transfer occurred
// - ERR_ADDR      out  32       HADDR of the first unmapped transfer since the last clear
// - ERR_CLR       in   1        synchronous clear of ERR_IRQ/ERR_ADDR (ERR_ADDR -> 0)
// BEHAVIOUR
// - Decode: combinational on HADDR_M; the lowest index wins on overlapping hits. HSEL_S[i] = win(i); no hit -> default slave (DS).
// - Request signals pass through unregistered; zero added latency on the address or data path.
// - Data-phase owner register dsel (NSLV+1 codes incl. DS): loads the decode result when HREADY_M=1, holds when 0; reset -> DS.
// - Data-phase valid flag dval: loads (HTRANS_M[1] & HREADY_M) when HREADY_M=1; reset 0.
// - Response mux by dsel: HRDATA_M/HREADY_M/HRESP_M = slave dsel; for DS, HRDATA_M = 32'h0.
// - A slave selected for IDLE/BUSY still drives its OKAY response; the mux does not filter it.
// - DS FSM states: DS_IDLE, DS_ERR1, DS_ERR2. Reset -> DS_IDLE.
//   - DS_IDLE: HREADY=1, HRESP=OKAY. NONSEQ/SEQ to DS with HREADY_M=1 -> DS_ERR1 next cycle.
//   - DS_ERR1: HREADY=0, HRESP=ERROR; always -> DS_ERR2.
//   - DS_ERR2: HREADY=1, HRESP=ERROR. A new unmapped NONSEQ/SEQ in this cycle -> DS_ERR1; otherwise -> DS_IDLE.
//   - IDLE/BUSY to unmapped space -> zero-wait OKAY (stays DS_IDLE).
// - Master may change HTRANS to IDLE during DS_ERR1/DS_ERR2; the address phase is accepted only when HREADY_M=1.
// - Error status: on an unmapped NONSEQ/SEQ accepted while ERR_IRQ=0, set ERR_IRQ=1 and latch ERR_ADDR.
//   - Later errors do not overwrite ERR_ADDR.
//   - ERR_CLR wins over a same-cycle set; the set is lost.
// - Reset values: HREADY_M=1, HRESP_M=00, HRDATA_M=0, ERR_IRQ=0, ERR_ADDR=0; HSEL_S follows the decode of the inputs.
// - Reset mid-transfer: all state returns to reset values asynchronously; no pending error survives.
// TESTING
// - Default map, NONSEQ read to slot 2 base, HREADYOUT_S[2] low 3 cycles -> HREADY_M low 3 cycles, HRDATA_M = slot 2 data.
// - Back-to-back NONSEQ writes slot0 -> slot4, slot0 waited 2 cycles -> slot4 address held; HSEL_S[4] seen at the accepted edge.
// - NONSEQ to unmapped 0xDEAD0000 -> cycle1 HREADY=0/RESP=01, cycle2 HREADY=1/RESP=01, ERR_IRQ=1, ERR_ADDR=0xDEAD0000.
// - Two consecutive unmapped NONSEQs -> ERR1,ERR2,ERR1,ERR2 sequence; ERR_ADDR keeps the first address.
// - IDLE to unmapped -> OKAY with zero wait states; ERR_IRQ unchanged. ERR_CLR with a same-cycle error -> ERR_IRQ=0.
// - HRESETn asserted during DS_ERR1 -> HREADY_M=1, HRESP_M=00 immediately; NSLV=1 build passes the same read test.

Source files
------------

// File: rtl/ahblite_subbus_nslave_if.sv
// AHB-Lite sub-bus signal bundle: one upstream master port plus NSLV broadcast slave ports.
// master = the surrounding bus (upstream master and slave models); slave = the sub-bus itself.
interface ahblite_subbus_nslave_if #(
  parameter int NSLV = 5
);
  logic [31:0]        HADDR_M;
  logic [1:0]         HTRANS_M;
  logic               HWRITE_M;
  logic [2:0]         HSIZE_M;
  logic [2:0]         HBURST_M;
  logic [3:0]         HPROT_M;
  logic [31:0]        HWDATA_M;
  logic [31:0]        HRDATA_M;
  logic               HREADY_M;
  logic [1:0]         HRESP_M;

  logic [NSLV-1:0]    HSEL_S;
  logic [31:0]        HADDR_S;
  logic [1:0]         HTRANS_S;
  logic               HWRITE_S;
  logic [2:0]         HSIZE_S;
  logic [2:0]         HBURST_S;
  logic [3:0]         HPROT_S;
  logic [31:0]        HWDATA_S;
  logic               HREADY_S;
  logic [NSLV*32-1:0] HRDATA_S;
  logic [NSLV-1:0]    HREADYOUT_S;
  logic [NSLV*2-1:0]  HRESP_S;

  modport master (
    output HADDR_M, HTRANS_M, HWRITE_M, HSIZE_M, HBURST_M, HPROT_M, HWDATA_M,
    input  HRDATA_M, HREADY_M, HRESP_M,
    input  HSEL_S, HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HBURST_S, HPROT_S, HWDATA_S, HREADY_S,
    output HRDATA_S, HREADYOUT_S, HRESP_S
  );

  modport slave (
    input  HADDR_M, HTRANS_M, HWRITE_M, HSIZE_M, HBURST_M, HPROT_M, HWDATA_M,
    output HRDATA_M, HREADY_M, HRESP_M,
    output HSEL_S, HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HBURST_S, HPROT_S, HWDATA_S, HREADY_S,
    input  HRDATA_S, HREADYOUT_S, HRESP_S
  );
endinterface

// File: rtl/ahblite_subbus_nslave.sv
// Single-master AHB-Lite interconnect fanning out to NSLV slaves, with a table-driven
// address map, a built-in two-cycle ERROR default slave and a sticky decode-error status.
module ahblite_subbus_nslave #(
  parameter int                 NSLV     = 5,
  parameter logic [NSLV*32-1:0] SLV_BASE = {NSLV{32'h0}},
  parameter logic [NSLV*32-1:0] SLV_MASK = {NSLV{32'hFFFF0000}}
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahblite_subbus_nslave_if.slave bus,
  input  logic                  ERR_CLR,
  output logic                  ERR_IRQ,
  output logic [31:0]           ERR_ADDR
);

  localparam int              IDXW       = $clog2(NSLV + 1);
  localparam logic [IDXW-1:0] DS_IDX     = IDXW'(NSLV);
  localparam logic [1:0]      RESP_OKAY  = 2'b00;
  localparam logic [1:0]      RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

  logic [IDXW-1:0] win;
  logic [IDXW-1:0] dsel;
  logic            dval;
  logic [NSLV-1:0] hsel;
  logic [31:0]     hrdata;
  logic            hready;
  logic [1:0]      hresp;
  logic            acc_err;
  ds_state_t       ds_state, ds_next;

  // Scan from the top down so the lowest matching index is the last write and wins.
  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    win  = DS_IDX;
    hsel = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((bus.HADDR_M & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) win = IDXW'(i);
    end
    for (int i = 0; i < NSLV; i++) begin
      if (win == IDXW'(i)) hsel[i] = 1'b1;
    end
  end

  assign bus.HSEL_S   = hsel;
  assign bus.HADDR_S  = bus.HADDR_M;
  assign bus.HTRANS_S = bus.HTRANS_M;
  assign bus.HWRITE_S = bus.HWRITE_M;
  assign bus.HSIZE_S  = bus.HSIZE_M;
  assign bus.HBURST_S = bus.HBURST_M;
  assign bus.HPROT_S  = bus.HPROT_M;
  assign bus.HWDATA_S = bus.HWDATA_M;
  assign bus.HREADY_S = hready;

  // Data-phase owner; the default slave answers whenever no real slave owns the phase.
  always_comb begin
    hrdata = '0;
    hready = (ds_state != DS_ERR1);
    hresp  = (ds_state == DS_IDLE) ? RESP_OKAY : RESP_ERROR;
    for (int i = 0; i < NSLV; i++) begin
      if (dsel == IDXW'(i)) begin
        hrdata = bus.HRDATA_S[32*i +: 32];
        hready = bus.HREADYOUT_S[i];
        hresp  = bus.HRESP_S[2*i +: 2];
      end
    end
  end

  assign bus.HRDATA_M = hrdata;
  assign bus.HREADY_M = hready;
  assign bus.HRESP_M  = hresp;

  assign acc_err = hready & bus.HTRANS_M[1] & (win == DS_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel <= DS_IDX;
      dval <= 1'b0;
    end else if (hready) begin
      dsel <= win;
      dval <= bus.HTRANS_M[1];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) ds_state <= DS_IDLE;
    else          ds_state <= ds_next;
  end

  always_comb begin
    ds_next = ds_state;
    unique case (ds_state)
      DS_IDLE: if (acc_err) ds_next = DS_ERR1;
      DS_ERR1: ds_next = DS_ERR2;
      DS_ERR2: ds_next = acc_err ? DS_ERR1 : DS_IDLE;
      default: ds_next = DS_IDLE;
    endcase
  end

  // Only the first unmapped transfer since a clear is recorded; a clear beats a same-cycle set.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ERR_IRQ  <= 1'b0;
      ERR_ADDR <= '0;
    end else if (ERR_CLR) begin
      ERR_IRQ  <= 1'b0;
      ERR_ADDR <= '0;
    end else if (acc_err && !ERR_IRQ) begin
      ERR_IRQ  <= 1'b1;
      ERR_ADDR <= bus.HADDR_M;
    end
  end

  // An ERROR data phase can only belong to an accepted transfer owned by the default slave.
  ds_owner_a: assert property (@(posedge HCLK) disable iff (!HRESETn)
    (ds_state != DS_IDLE) |-> (dsel == DS_IDX && dval));

endmodule

// File: tb/tb_ahblite_subbus_nslave.sv
// Directed bench for ahblite_subbus_nslave: a 5-slave build and a 1-slave build share the clock.
module tb_ahblite_subbus_nslave;

  localparam int                 NSLV   = 5;
  localparam logic [NSLV*32-1:0] BASES  = {32'h4004_0000, 32'h4003_0000, 32'h4002_0000,
                                           32'h4001_0000, 32'h4000_0000};
  localparam logic [NSLV*32-1:0] MASKS  = {NSLV{32'hFFFF_0000}};
  localparam logic [1:0]         IDLE   = 2'b00;
  localparam logic [1:0]         NONSEQ = 2'b10;

  logic        HCLK    = 1'b0;
  logic        HRESETn = 1'b0;
  logic        err_clr, err_irq, err_clr1, err_irq1;
  logic [31:0] err_addr, err_addr1;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 HCLK = ~HCLK;

  ahblite_subbus_nslave_if #(.NSLV(NSLV)) bus ();
  ahblite_subbus_nslave_if #(.NSLV(1))    bus1 ();

  ahblite_subbus_nslave #(.NSLV(NSLV), .SLV_BASE(BASES), .SLV_MASK(MASKS)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus),
    .ERR_CLR(err_clr), .ERR_IRQ(err_irq), .ERR_ADDR(err_addr)
  );

  ahblite_subbus_nslave #(.NSLV(1), .SLV_BASE(32'h4000_0000), .SLV_MASK(32'hFFFF_0000)) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .bus(bus1),
    .ERR_CLR(err_clr1), .ERR_IRQ(err_irq1), .ERR_ADDR(err_addr1)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic req(input logic [31:0] addr, input logic [1:0] trans, input logic write);
    bus.HADDR_M  = addr;
    bus.HTRANS_M = trans;
    bus.HWRITE_M = write;
  endtask

  task automatic req1(input logic [31:0] addr, input logic [1:0] trans);
    bus1.HADDR_M  = addr;
    bus1.HTRANS_M = trans;
  endtask

  initial begin
    bus.HSIZE_M      = 3'b010;
    bus.HBURST_M     = 3'b000;
    bus.HPROT_M      = 4'b0011;
    bus.HWDATA_M     = '0;
    bus.HRDATA_S     = {32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
    bus.HREADYOUT_S  = '1;
    bus.HRESP_S      = '0;
    bus1.HWRITE_M    = 1'b0;
    bus1.HSIZE_M     = 3'b010;
    bus1.HBURST_M    = 3'b000;
    bus1.HPROT_M     = 4'b0011;
    bus1.HWDATA_M    = '0;
    bus1.HRDATA_S    = 32'hB000_0000;
    bus1.HREADYOUT_S = 1'b1;
    bus1.HRESP_S     = 2'b00;
    err_clr  = 1'b0;
    err_clr1 = 1'b0;
    req(32'h4001_0000, IDLE, 1'b0);
    req1(32'h0000_0000, IDLE);

    // Reset state
    repeat (2) tick();
    check("rst_hready", 32'(bus.HREADY_M), 32'd1);
    check("rst_hresp", 32'(bus.HRESP_M), 32'd0);
    check("rst_hrdata", bus.HRDATA_M, 32'h0);
    check("rst_irq", 32'(err_irq), 32'd0);
    check("rst_err_addr", err_addr, 32'h0);
    check("rst_hsel", 32'(bus.HSEL_S), 32'b00010);
    check("rst1_hready", 32'(bus1.HREADY_M), 32'd1);
    check("rst1_irq", 32'(err_irq1), 32'd0);
    check("rst1_err_addr", err_addr1, 32'h0);
    HRESETn = 1'b1;

    // Read of slot 2 with three wait states
    tick(); req(32'h4002_0000, NONSEQ, 1'b0); settle();
    check("rd_hsel", 32'(bus.HSEL_S), 32'b00100);
    check("rd_addr_hready", 32'(bus.HREADY_M), 32'd1);
    tick(); req(32'h0, IDLE, 1'b0); bus.HREADYOUT_S[2] = 1'b0; settle();
    check("rd_wait1", 32'(bus.HREADY_M), 32'd0);
    tick(); settle();
    check("rd_wait2", 32'(bus.HREADY_M), 32'd0);
    tick(); settle();
    check("rd_wait3", 32'(bus.HREADY_M), 32'd0);
    tick(); bus.HREADYOUT_S[2] = 1'b1; settle();
    check("rd_done_hready", 32'(bus.HREADY_M), 32'd1);
    check("rd_data", bus.HRDATA_M, 32'hA000_0002);
    check("rd_resp", 32'(bus.HRESP_M), 32'd0);

    // Back-to-back writes slot0 -> slot4, slot0 stalls two cycles
    tick(); req(32'h4000_0000, NONSEQ, 1'b1); settle();
    check("wr0_hsel", 32'(bus.HSEL_S), 32'b00001);
    tick(); req(32'h4004_0000, NONSEQ, 1'b1); bus.HWDATA_M = 32'h1111_0000;
    bus.HREADYOUT_S[0] = 1'b0; settle();
    check("wr0_wait1", 32'(bus.HREADY_M), 32'd0);
    check("wr4_hsel_held", 32'(bus.HSEL_S), 32'b10000);
    check("wr4_haddr_s", bus.HADDR_S, 32'h4004_0000);
    check("wr0_hwdata_s", bus.HWDATA_S, 32'h1111_0000);
    tick(); settle();
    check("wr0_wait2", 32'(bus.HREADY_M), 32'd0);
    tick(); bus.HREADYOUT_S[0] = 1'b1; settle();
    check("wr0_done_hready", 32'(bus.HREADY_M), 32'd1);
    check("wr4_hsel_accept", 32'(bus.HSEL_S), 32'b10000);
    tick(); req(32'h0, IDLE, 1'b0); bus.HWDATA_M = 32'h4444_0004; settle();
    check("wr4_hready", 32'(bus.HREADY_M), 32'd1);
    check("wr4_owner", bus.HRDATA_M, 32'hA000_0004);
    check("wr4_hwdata_s", bus.HWDATA_S, 32'h4444_0004);

    // Single unmapped NONSEQ
    tick(); req(32'hDEAD_0000, NONSEQ, 1'b0); settle();
    check("um_hsel", 32'(bus.HSEL_S), 32'b00000);
    check("um_addr_hready", 32'(bus.HREADY_M), 32'd1);
    tick(); req(32'h0, IDLE, 1'b0); settle();
    check("um_err1_hready", 32'(bus.HREADY_M), 32'd0);
    check("um_err1_resp", 32'(bus.HRESP_M), 32'd1);
    check("um_err1_hrdata", bus.HRDATA_M, 32'h0);
    check("um_irq", 32'(err_irq), 32'd1);
    check("um_err_addr", err_addr, 32'hDEAD_0000);
    tick(); settle();
    check("um_err2_hready", 32'(bus.HREADY_M), 32'd1);
    check("um_err2_resp", 32'(bus.HRESP_M), 32'd1);
    tick(); settle();
    check("um_post_resp", 32'(bus.HRESP_M), 32'd0);

    // Clear the status
    err_clr = 1'b1; tick(); err_clr = 1'b0; settle();
    check("clr_irq", 32'(err_irq), 32'd0);
    check("clr_err_addr", err_addr, 32'h0);

    // Two consecutive unmapped NONSEQs
    tick(); req(32'hBEEF_0000, NONSEQ, 1'b0); settle();
    tick(); req(32'hCAFE_0000, NONSEQ, 1'b0); settle();
    check("b2b_e1_hready", 32'(bus.HREADY_M), 32'd0);
    check("b2b_e1_resp", 32'(bus.HRESP_M), 32'd1);
    tick(); settle();
    check("b2b_e2_hready", 32'(bus.HREADY_M), 32'd1);
    check("b2b_e2_resp", 32'(bus.HRESP_M), 32'd1);
    tick(); req(32'h0, IDLE, 1'b0); settle();
    check("b2b_e3_hready", 32'(bus.HREADY_M), 32'd0);
    check("b2b_e3_resp", 32'(bus.HRESP_M), 32'd1);
    check("b2b_err_addr", err_addr, 32'hBEEF_0000);
    tick(); settle();
    check("b2b_e4_hready", 32'(bus.HREADY_M), 32'd1);
    check("b2b_e4_resp", 32'(bus.HRESP_M), 32'd1);
    tick(); settle();
    check("b2b_post_resp", 32'(bus.HRESP_M), 32'd0);

    // IDLE to unmapped space, then a clear colliding with a new error
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    req(32'hDEAD_0000, IDLE, 1'b0); settle();
    tick(); settle();
    check("idle_hready", 32'(bus.HREADY_M), 32'd1);
    check("idle_resp", 32'(bus.HRESP_M), 32'd0);
    check("idle_irq", 32'(err_irq), 32'd0);
    req(32'hDEAD_0000, NONSEQ, 1'b0); err_clr = 1'b1;
    tick(); err_clr = 1'b0; req(32'h0, IDLE, 1'b0); settle();
    check("sc_irq", 32'(err_irq), 32'd0);
    check("sc_err_addr", err_addr, 32'h0);
    check("sc_resp", 32'(bus.HRESP_M), 32'd1);
    repeat (2) tick();

    // Reset asserted during DS_ERR1
    req(32'hDEAD_0000, NONSEQ, 1'b0);
    tick(); req(32'h0, IDLE, 1'b0); settle();
    check("pre_rst_hready", 32'(bus.HREADY_M), 32'd0);
    check("pre_rst_irq", 32'(err_irq), 32'd1);
    HRESETn = 1'b0; #1;
    check("midrst_hready", 32'(bus.HREADY_M), 32'd1);
    check("midrst_resp", 32'(bus.HRESP_M), 32'd0);
    check("midrst_irq", 32'(err_irq), 32'd0);
    check("midrst_err_addr", err_addr, 32'h0);
    tick(); HRESETn = 1'b1;
    tick(); settle();
    check("postrst_resp", 32'(bus.HRESP_M), 32'd0);

    // NSLV=1 build: same read with three wait states
    tick(); req1(32'h4000_0010, NONSEQ); settle();
    check("n1_hsel", 32'(bus1.HSEL_S), 32'd1);
    tick(); req1(32'h0, IDLE); bus1.HREADYOUT_S = 1'b0; settle();
    check("n1_wait1", 32'(bus1.HREADY_M), 32'd0);
    tick(); settle();
    check("n1_wait2", 32'(bus1.HREADY_M), 32'd0);
    tick(); settle();
    check("n1_wait3", 32'(bus1.HREADY_M), 32'd0);
    tick(); bus1.HREADYOUT_S = 1'b1; settle();
    check("n1_done_hready", 32'(bus1.HREADY_M), 32'd1);
    check("n1_data", bus1.HRDATA_M, 32'hB000_0000);
    check("n1_resp", 32'(bus1.HRESP_M), 32'd0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
